uart_tx_arbiter: RTL and testbench

//  Shares one async_transmitter among NUM_REQ byte requesters using round-robin arbitration.

---
 rtl/uart_arb_pkg.sv | 26 ++
 rtl/uart_tx_arbiter_rr_select.sv | 56 +++++
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// a width helper used for requester indices and the busy-timeout counter.
package uart_arb_pkg;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    // Ceiling log2, never below 1 so a single-requester build keeps a legal vector.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: combinational round-robin picker. Searches the request vector
// starting one past the pointer with wrap-around and returns a one-hot grant
// plus its index. With UART_ARB_LOCK_EN defined, an active lock masks every
// requester except lock_id.
module rr_select
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
`ifdef UART_ARB_LOCK_EN
    input  logic               lock,
    input  logic [ID_W-1:0]    lock_id,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid
);

    logic [NUM_REQ-1:0] req_eff;

    genvar gi;

`ifdef UART_ARB_LOCK_EN
    // While locked, only the owning requester is visible to the search.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lock_mask
            assign req_eff[gi] = req[gi] & (~lock | (lock_id == ID_W'(gi)));
        end
    endgenerate
`else
    assign req_eff = req;
`endif

    // First eligible requester after ptr, wrapping; ptr itself is checked last.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_valid && req_eff[(int'(ptr) + k) % NUM_REQ]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    // One-hot form of the selected index.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant[gi] = grant_valid && (grant_id == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte sources.
// One byte is accepted per valid/ready handshake in idle, the transmitter gets
// a one-cycle start pulse, then the arbiter waits for busy to rise and fall
// (or for BUSY_TIMEOUT cycles without a rise) before accepting the next byte.
// Optional feature: define UART_ARB_LOCK_EN to keep the grant on one requester
// until it hands over a byte flagged with req_last.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  BUSY_TIMEOUT = 15,
    localparam int ID_W         = clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 txd_start,
    output logic [7:0]           txd_data,
    input  logic                 txd_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 active
);

    localparam int               CNT_W     = clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [ID_W-1:0]  PTR_RESET = ID_W'(NUM_REQ - 1);

    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [ID_W-1:0]    ptr_reg;
    logic [ID_W-1:0]    grant_id_reg;
    logic [7:0]         data_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [NUM_REQ-1:0] sel_grant;
    logic [ID_W-1:0]    sel_id;
    logic               sel_valid;
    logic               idle_ready;
    logic               handshake;
    logic [7:0]         req_byte [NUM_REQ];

    genvar gi;

    // Unpack the flat data bus into one byte per requester.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

`ifdef UART_ARB_LOCK_EN
    logic            lock_reg;
    logic [ID_W-1:0] lock_id_reg;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_select (
        .req         (req_valid),
        .ptr         (ptr_reg),
        .lock        (lock_reg),
        .lock_id     (lock_id_reg),
        .grant       (sel_grant),
        .grant_id    (sel_id),
        .grant_valid (sel_valid)
    );

    // Packet lock: a byte without req_last keeps the grant on its requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_reg    <= 1'b0;
            lock_id_reg <= '0;
        end else if (handshake) begin
            lock_reg    <= ~req_last[sel_id];
            lock_id_reg <= sel_id;
        end
    end
`else
    logic unused_req_last;
    assign unused_req_last = ^req_last;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_select (
        .req         (req_valid),
        .ptr         (ptr_reg),
        .grant       (sel_grant),
        .grant_id    (sel_id),
        .grant_valid (sel_valid)
    );
`endif

    // Ready only in idle with the transmitter free; a busy line after reset blocks grants.
    assign idle_ready = (state_reg == S_IDLE) && !txd_busy;
    assign req_ready  = idle_ready ? sel_grant : '0;
    assign handshake  = idle_ready && sel_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start pulse, wait for busy rise (bounded), wait for busy fall.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (handshake) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (txd_busy) begin
                    state_next = S_WAIT_DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!txd_busy) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        txd_start = (state_reg == S_START);
        active    = (state_reg != S_IDLE);
    end

    // Accepted byte, grant index and rotation pointer captured on the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg     <= 8'h00;
            grant_id_reg <= '0;
            ptr_reg      <= PTR_RESET;
        end else if (handshake) begin
            data_reg     <= req_byte[sel_id];
            grant_id_reg <= sel_id;
            ptr_reg      <= sel_id;
        end
    end

    // Cycles spent waiting for busy to rise; cleared outside that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (state_reg == S_WAIT_BUSY) begin
            cnt_reg <= cnt_reg + 1'b1;
        end else begin
            cnt_reg <= '0;
        end
    end

    assign txd_data = data_reg;
    assign grant_id = grant_id_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter with a behavioural UART transmitter
// (8 clocks per bit, 96 MHz / 12 Mbaud) and a line receiver that rebuilds
// the serialised bytes. Expected orders and data are hand-computed tables.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        txd_start;
    logic [7:0]  txd_data;
    logic        txd_busy;
    logic [1:0]  grant_id;
    logic        active;

    logic        force_busy = 1'b0;
    logic        stub_mode  = 1'b0;

    logic        model_busy = 1'b0;
    logic [9:0]  tx_shift   = 10'h3ff;
    int          baud_cnt   = 0;
    int          bit_cnt    = 0;
    logic        txd_line;
    logic [7:0]  rx_byte;

    int vec_cnt = 0;
    int err_cnt = 0;
    int src_left [4];
    int start_id_q [$];
    int start_data_q [$];
    int hs_q [$];
    int rx_q [$];

    int exp_rr_id   [5] = '{0, 1, 2, 3, 0};
    int exp_rr_data [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
`ifdef UART_ARB_LOCK_EN
    int exp_pkt_id  [5] = '{1, 1, 1, 0, 0};
`else
    int exp_pkt_id  [5] = '{1, 0, 1, 0, 1};
`endif

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .txd_start (txd_start),
        .txd_data  (txd_data),
        .txd_busy  (txd_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    assign txd_busy = force_busy | model_busy;
    assign txd_line = model_busy ? tx_shift[0] : 1'b1;

    // Transmitter model: start bit, 8 data bits LSB first, stop bit, 8 clocks each.
    always @(posedge clk) begin
        if (!model_busy) begin
            if (txd_start && !stub_mode) begin
                model_busy <= 1'b1;
                tx_shift   <= {1'b1, txd_data, 1'b0};
                baud_cnt   <= 0;
                bit_cnt    <= 0;
            end
        end else if (baud_cnt == 7) begin
            baud_cnt <= 0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            bit_cnt  <= bit_cnt + 1;
            if (bit_cnt == 9) begin
                model_busy <= 1'b0;
            end
        end else begin
            baud_cnt <= baud_cnt + 1;
        end
    end

    // Line receiver: mid-bit sampling from the start-bit falling edge.
    initial begin
        forever begin
            @(negedge txd_line);
            repeat (4) @(posedge clk);
            for (int b = 0; b < 8; b++) begin
                repeat (8) @(posedge clk);
                rx_byte[b] = txd_line;
            end
            rx_q.push_back(int'(rx_byte));
            $display("rx: byte %02h", rx_byte);
        end
    end

    // Transaction log: handshakes and start pulses.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hs_q.push_back(i);
                end
            end
        end
        if (txd_start) begin
            start_id_q.push_back(int'(grant_id));
            start_data_q.push_back(int'(txd_data));
            $display("txn: start grant %0d data %02h", grant_id, txd_data);
        end
    end

    task automatic check_equal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Configure requester i: n bytes (negative = endless single-byte packets).
    task automatic src_set(input int i, input logic [7:0] data, input int n);
        req_data[8*i +: 8] = data;
        src_left[i]        = n;
        req_valid[i]       = (n != 0);
        req_last[i]        = (n < 0) || (n == 1);
    endtask

    // One clock: note handshakes before the edge, update sources just after it.
    task automatic tick();
        logic [3:0] hs;
        @(negedge clk);
        hs = reset ? 4'b0000 : (req_valid & req_ready);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs[i]) begin
                if (src_left[i] > 0) begin
                    src_left[i]--;
                end
                if (src_left[i] == 0) begin
                    req_valid[i] = 1'b0;
                end
                req_last[i] = (src_left[i] < 0) || (src_left[i] == 1);
            end
        end
    endtask

    task automatic clear_logs();
        start_id_q.delete();
        start_data_q.delete();
        hs_q.delete();
        rx_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) src_set(i, 8'h00, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int c = 0;
        while (start_data_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        check_equal(tag, start_data_q.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int c = 0;
        while (active && c < budget) begin
            tick();
            c++;
        end
        check_equal(tag, active, 1'b0);
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        check_equal(tag, rx_q.size(), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;

        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < 4; i++) src_left[i] = 0;
        tick();
        tick();
        check_equal("rst_txd_start", txd_start, 1'b0);
        check_equal("rst_txd_data", txd_data, 8'h00);
        check_equal("rst_grant_id", grant_id, 2'd0);
        check_equal("rst_active", active, 1'b0);
        check_equal("rst_req_ready", req_ready, 4'b0000);
        reset = 1'b0;

        // Single byte from requester 0
        clear_logs();
        src_set(0, 8'hA5, 1);
        #1;
        check_equal("t1_ready_before", req_ready, 4'b0001);
        tick();
        check_equal("t1_ready_after", req_ready, 4'b0000);
        check_equal("t1_start", txd_start, 1'b1);
        check_equal("t1_data", txd_data, 8'hA5);
        check_equal("t1_active", active, 1'b1);
        check_equal("t1_grant_id", grant_id, 2'd0);
        tick();
        check_equal("t1_start_pulse_end", txd_start, 1'b0);
        wait_idle(200, "t1_idle");
        wait_rx(1, 50, "t1_rx_count");
        check_equal("t1_rx_byte", rx_q[0], 8'hA5);

        // Round robin with all requesters valid
        do_reset();
        clear_logs();
        for (int i = 0; i < 4; i++) src_set(i, 8'h10 + 8'(i), -1);
        wait_starts(5, 1000, "t2_starts");
        for (int i = 0; i < 4; i++) src_set(i, 8'h00, 0);
        wait_idle(200, "t2_idle");
        for (int i = 0; i < 5; i++) begin
            check_equal($sformatf("t2_grant_%0d", i), start_id_q[i], exp_rr_id[i]);
            check_equal($sformatf("t2_data_%0d", i), start_data_q[i], exp_rr_data[i]);
        end
        wait_rx(5, 50, "t2_rx_count");
        for (int i = 0; i < 5; i++) begin
            check_equal($sformatf("t2_rx_%0d", i), rx_q[i], exp_rr_data[i]);
        end

        // Busy held high in idle
        clear_logs();
        force_busy = 1'b1;
        src_set(2, 8'h22, 1);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (req_ready != 4'b0000) seen = 1'b1;
        end
        check_equal("t3_ready_held", seen, 1'b0);
        check_equal("t3_no_start", start_data_q.size(), 0);
        force_busy = 1'b0;
        wait_starts(1, 20, "t3_start");
        check_equal("t3_grant_id", start_id_q[0], 2);
        check_equal("t3_data", start_data_q[0], 8'h22);
        wait_idle(200, "t3_idle");

        // Busy never rises: timeout
        clear_logs();
        stub_mode = 1'b1;
        src_set(3, 8'h33, 1);
        wait_starts(1, 20, "t4_start");
        n = 0;
        while (active && n < 100) begin
            tick();
            n++;
        end
        check_equal("t4_timeout_cycles", n, BUSY_TIMEOUT);
        src_set(1, 8'h44, 1);
        wait_starts(2, 20, "t4_next_start");
        check_equal("t4_next_grant", start_id_q[1], 1);
        check_equal("t4_next_data", start_data_q[1], 8'h44);
        wait_idle(50, "t4_idle");
        stub_mode = 1'b0;

        // Reset while waiting for busy to fall
        clear_logs();
        src_set(0, 8'h55, 1);
        wait_starts(1, 20, "t5_start");
        repeat (3) tick();
        check_equal("t5_pre_active", active, 1'b1);
        check_equal("t5_pre_busy", txd_busy, 1'b1);
        reset = 1'b1;
        src_set(0, 8'h66, 1);
        src_set(3, 8'h77, 1);
        tick();
        check_equal("t5_rst_start", txd_start, 1'b0);
        check_equal("t5_rst_data", txd_data, 8'h00);
        check_equal("t5_rst_grant_id", grant_id, 2'd0);
        check_equal("t5_rst_active", active, 1'b0);
        check_equal("t5_rst_ready", req_ready, 4'b0000);
        reset = 1'b0;
        n = 0;
        while (txd_busy && n < 200) begin
            tick();
            n++;
        end
        check_equal("t5_busy_fell", txd_busy, 1'b0);
        check_equal("t5_no_grant_while_busy", start_data_q.size(), 1);
        wait_starts(2, 20, "t5_first_after_reset");
        check_equal("t5_ptr_restart_grant", start_id_q[1], 0);
        check_equal("t5_ptr_restart_data", start_data_q[1], 8'h66);
        wait_idle(200, "t5_idle1");
        wait_starts(3, 20, "t5_second_after_reset");
        check_equal("t5_second_grant", start_id_q[2], 3);
        check_equal("t5_second_data", start_data_q[2], 8'h77);
        wait_idle(200, "t5_idle2");
        wait_rx(3, 50, "t5_rx_count");
        check_equal("t5_rx_0", rx_q[0], 8'h55);
        check_equal("t5_rx_1", rx_q[1], 8'h66);
        check_equal("t5_rx_2", rx_q[2], 8'h77);

        // Three-byte packet from requester 1 against an always-valid requester 0
        do_reset();
        clear_logs();
        src_set(1, 8'h81, 3);
        n = 0;
        while (hs_q.size() == 0 && n < 10) begin
            tick();
            n++;
        end
        check_equal("t6_first_hs", hs_q.size(), 1);
        src_set(0, 8'h90, -1);
        wait_starts(5, 1000, "t6_starts");
        for (int i = 0; i < 4; i++) src_set(i, 8'h00, 0);
        wait_idle(200, "t6_idle");
        for (int i = 0; i < 5; i++) begin
            check_equal($sformatf("t6_grant_%0d", i), start_id_q[i], exp_pkt_id[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
